// File: rtl/quad_step_encoder.sv
// rtl/quad_step_encoder.sv - quadrature detent encoder with debounced press commit
module quad_step_encoder #(
  parameter int WIDTH       = 10,
  parameter int MAX_VAL     = 360,
  parameter int STEP        = 18,
  parameter int INIT_VAL    = 0,
  parameter int WRAP        = 1,
  parameter int DEB_CYCLES  = 4,
  parameter int FAST_WINDOW = 0,
  parameter int FAST_MULT   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             rot_a,
  input  logic             rot_b,
  input  logic             rot_press,
  output logic [WIDTH-1:0] position,
  output logic [WIDTH-1:0] committed_value,
  output logic             commit_pulse,
  output logic             step_pulse,
  output logic             step_dir
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int GW = $clog2(FAST_WINDOW + 2);
  localparam int AW = WIDTH + 1;

  localparam logic [AW-1:0]    MAX_EXT   = AW'(MAX_VAL);
  localparam logic [AW-1:0]    LAST_EXT  = AW'(MAX_VAL - 1);
  localparam logic [AW-1:0]    STEP_SLOW = AW'(STEP);
  localparam logic [AW-1:0]    STEP_FAST = AW'(STEP * FAST_MULT);
  localparam logic [DW-1:0]    DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [GW-1:0]    GAP_MAX   = GW'(FAST_WINDOW);
  localparam logic [WIDTH-1:0] INIT_POS  = WIDTH'(INIT_VAL);

  // bit 0 = A, bit 1 = B, bit 2 = press
  logic [2:0]       raw_in;
  logic [2:0]       sync1;
  logic [2:0]       sync2;
  logic [2:0]       deb;
  logic [DW-1:0]    deb_cnt [3];

  logic             evt_q;
  logic             evt_d;
  logic             evt_prev;
  logic             dir_q;
  logic             dir_d;
  logic             press_q;
  logic             detent;
  logic             press_edge;

  logic [GW-1:0]    gap_cnt;
  logic [AW-1:0]    step_amt;
  logic [AW-1:0]    pos_ext;
  logic [AW-1:0]    pos_sum;
  logic [WIDTH-1:0] next_pos;

  assign raw_in = {rot_press, rot_b, rot_a};

  // Two-flop synchronisers for the asynchronous rotary and button inputs
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
    end
  end

  // Per-input debounce: accept a new level only after DEB_CYCLES stable mismatching cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      deb <= '0;
      for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Detent tracker state register; runs regardless of enable so re-enabling mid-turn is clean
  always_ff @(posedge clk) begin
    if (reset) begin
      evt_q    <= 1'b0;
      evt_prev <= 1'b0;
      dir_q    <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      evt_q    <= evt_d;
      evt_prev <= evt_q;
      dir_q    <= dir_d;
      press_q  <= deb[2];
    end
  end

  // Detent tracker next state from debounced {b,a}
  always_comb begin
    evt_d = evt_q;
    dir_d = dir_q;
    case (deb[1:0])
      2'b00:   evt_d = 1'b0;
      2'b11:   evt_d = 1'b1;
      2'b01:   dir_d = 1'b0;
      2'b10:   dir_d = 1'b1;
      default: ;
    endcase
  end

  // Tracker outputs: detent on rising event, press on rising debounced button
  always_comb begin
    detent     = evt_q & ~evt_prev;
    press_edge = deb[2] & ~press_q;
  end

  // Next position with fast-spin step and wrap/saturate at the range ends
  always_comb begin
    step_amt = STEP_SLOW;
    if (FAST_WINDOW > 0 && gap_cnt < GAP_MAX) step_amt = STEP_FAST;
    pos_ext  = {1'b0, position};
    pos_sum  = pos_ext + step_amt;
    next_pos = position;
    if (!dir_q) begin
      if (pos_sum <= LAST_EXT)  next_pos = WIDTH'(pos_sum);
      else if (WRAP != 0)       next_pos = WIDTH'(pos_sum - MAX_EXT);
      else                      next_pos = WIDTH'(LAST_EXT);
    end else begin
      if (pos_ext >= step_amt)  next_pos = WIDTH'(pos_ext - step_amt);
      else if (WRAP != 0)       next_pos = WIDTH'(pos_ext + MAX_EXT - step_amt);
      else                      next_pos = '0;
    end
  end

  // Position, detent gap, commit capture and one-cycle strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      position        <= INIT_POS;
      committed_value <= INIT_POS;
      commit_pulse    <= 1'b0;
      step_pulse      <= 1'b0;
      step_dir        <= 1'b0;
      gap_cnt         <= GAP_MAX;
    end else begin
      step_pulse   <= 1'b0;
      commit_pulse <= 1'b0;
      if (enable && detent) begin
        position   <= next_pos;
        step_pulse <= 1'b1;
        step_dir   <= dir_q;
        gap_cnt    <= '0;
      end else if (gap_cnt < GAP_MAX) begin
        gap_cnt <= gap_cnt + 1'b1;
      end
      // committed_value samples the pre-update position when a detent lands on the same edge
      if (enable && press_edge) begin
        committed_value <= position;
        commit_pulse    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_quad_step_encoder.sv
// tb/tb_quad_step_encoder.sv - scoreboard bench for quad_step_encoder
module tb_quad_step_encoder;

  typedef struct {
    int   id;
    logic dir;
    int   val;
  } step_t;

  typedef struct {
    int id;
    int val;
  } commit_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       en  [3];
  logic       ra  [3];
  logic       rb  [3];
  logic       rp  [3];
  logic [9:0] pos [3];
  logic [9:0] cval[3];
  logic       cp  [3];
  logic       sp  [3];
  logic       sd  [3];

  step_t   step_q[$];
  commit_t com_q[$];
  int      checks = 0;
  int      errors = 0;

  always #5 clk = ~clk;

  quad_step_encoder u_def (
    .clk(clk), .reset(reset), .enable(en[0]), .rot_a(ra[0]), .rot_b(rb[0]), .rot_press(rp[0]),
    .position(pos[0]), .committed_value(cval[0]), .commit_pulse(cp[0]),
    .step_pulse(sp[0]), .step_dir(sd[0])
  );

  quad_step_encoder #(.WRAP(0)) u_sat (
    .clk(clk), .reset(reset), .enable(en[1]), .rot_a(ra[1]), .rot_b(rb[1]), .rot_press(rp[1]),
    .position(pos[1]), .committed_value(cval[1]), .commit_pulse(cp[1]),
    .step_pulse(sp[1]), .step_dir(sd[1])
  );

  quad_step_encoder #(.FAST_WINDOW(100), .FAST_MULT(5)) u_fast (
    .clk(clk), .reset(reset), .enable(en[2]), .rot_a(ra[2]), .rot_b(rb[2]), .rot_press(rp[2]),
    .position(pos[2]), .committed_value(cval[2]), .commit_pulse(cp[2]),
    .step_pulse(sp[2]), .step_dir(sd[2])
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic set_ab(input int k, input logic b, input logic a, input int n);
    ra[k] = a;
    rb[k] = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic detent(input int k, input bit ccw, input bit expect_pulse, input int exp_pos);
    if (expect_pulse) step_q.push_back('{k, ccw, exp_pos});
    if (ccw) begin
      set_ab(k, 1'b1, 1'b0, 10);
      set_ab(k, 1'b1, 1'b1, 10);
      set_ab(k, 1'b0, 1'b1, 10);
    end else begin
      set_ab(k, 1'b0, 1'b1, 10);
      set_ab(k, 1'b1, 1'b1, 10);
      set_ab(k, 1'b1, 1'b0, 10);
    end
    set_ab(k, 1'b0, 1'b0, 10);
  endtask

  // Monitor: every strobe must match the oldest expected event
  always @(negedge clk) begin
    step_t   se;
    commit_t ce;
    for (int k = 0; k < 3; k++) begin
      if (sp[k] === 1'b1) begin
        checks++;
        if (step_q.size() == 0) begin
          errors++;
          $display("FAIL step_unexpected dut%0d: got pulse pos=%0d, required no pulse", k, pos[k]);
        end else begin
          se = step_q.pop_front();
          if (se.id != k || sd[k] !== se.dir || pos[k] !== 10'(se.val)) begin
            errors++;
            $display("FAIL step dut%0d: got dir=%0d pos=%0d, required dut%0d dir=%0d pos=%0d",
                     k, sd[k], pos[k], se.id, se.dir, se.val);
          end
        end
      end
      if (cp[k] === 1'b1) begin
        checks++;
        if (com_q.size() == 0) begin
          errors++;
          $display("FAIL commit_unexpected dut%0d: got pulse value=%0d, required no pulse", k, cval[k]);
        end else begin
          ce = com_q.pop_front();
          if (ce.id != k || cval[k] !== 10'(ce.val)) begin
            errors++;
            $display("FAIL commit dut%0d: got value=%0d, required dut%0d value=%0d",
                     k, cval[k], ce.id, ce.val);
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      en[k] = 1'b1; ra[k] = 1'b0; rb[k] = 1'b0; rp[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_pos%0d", k), int'(pos[k]), 0);
      chk($sformatf("reset_cval%0d", k), int'(cval[k]), 0);
      chk($sformatf("reset_cp%0d", k), int'(cp[k]), 0);
      chk($sformatf("reset_sp%0d", k), int'(sp[k]), 0);
      chk($sformatf("reset_sd%0d", k), int'(sd[k]), 0);
    end

    // First CW detent with exact latency from the raw 01->11 transition
    step_q.push_back('{0, 1'b0, 18});
    set_ab(0, 1'b0, 1'b1, 10);
    ra[0] = 1'b1; rb[0] = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    chk("latency_pos_before", int'(pos[0]), 0);
    chk("latency_sp_before", int'(sp[0]), 0);
    @(posedge clk);
    #1;
    chk("latency_pos_after", int'(pos[0]), 18);
    chk("latency_sp_after", int'(sp[0]), 1);
    chk("latency_dir", int'(sd[0]), 0);
    repeat (2) @(negedge clk);
    set_ab(0, 1'b1, 1'b0, 10);
    set_ab(0, 1'b0, 1'b0, 10);

    // 19 more CW detents: 19th lands on 342, 20th wraps to 0
    for (int i = 2; i <= 20; i++) detent(0, 1'b0, 1'b1, (18 * i) % 360);
    detent(0, 1'b1, 1'b1, 342);

    // Glitches shorter than the debounce window are ignored
    ra[0] = 1'b1; rp[0] = 1'b1;
    repeat (3) @(negedge clk);
    ra[0] = 1'b0; rp[0] = 1'b0;
    repeat (20) @(negedge clk);
    chk("glitch_pos", int'(pos[0]), 342);

    // Detent and press while disabled are dropped
    en[0] = 1'b0;
    detent(0, 1'b0, 1'b0, 0);
    rp[0] = 1'b1;
    repeat (20) @(negedge clk);
    rp[0] = 1'b0;
    repeat (20) @(negedge clk);
    en[0] = 1'b1;
    repeat (10) @(negedge clk);
    chk("disabled_pos", int'(pos[0]), 342);
    chk("disabled_cval", int'(cval[0]), 0);

    // Held press commits once
    com_q.push_back('{0, 342});
    rp[0] = 1'b1;
    repeat (30) @(negedge clk);
    rp[0] = 1'b0;
    repeat (20) @(negedge clk);
    chk("press_cval", int'(cval[0]), 342);

    // Reset on the edge where a detent would have registered
    set_ab(0, 1'b0, 1'b1, 10);
    set_ab(0, 1'b1, 1'b1, 7);
    reset = 1'b1;
    ra[0] = 1'b0; rb[0] = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("midreset_pos", int'(pos[0]), 0);
    chk("midreset_cval", int'(cval[0]), 0);
    repeat (20) @(negedge clk);

    // Press edge coinciding with a detent: commit sees the old position
    detent(0, 1'b0, 1'b1, 18);
    detent(0, 1'b0, 1'b1, 36);
    step_q.push_back('{0, 1'b0, 54});
    com_q.push_back('{0, 36});
    set_ab(0, 1'b0, 1'b1, 10);
    set_ab(0, 1'b1, 1'b1, 1);
    rp[0] = 1'b1;
    set_ab(0, 1'b1, 1'b1, 9);
    set_ab(0, 1'b1, 1'b0, 10);
    rp[0] = 1'b0;
    set_ab(0, 1'b0, 1'b0, 20);
    chk("simul_cval", int'(cval[0]), 36);
    chk("simul_pos", int'(pos[0]), 54);

    // Saturating instance: CCW at 0 holds 0, CW past the top holds 359
    detent(1, 1'b1, 1'b1, 0);
    for (int i = 1; i <= 19; i++) detent(1, 1'b0, 1'b1, 18 * i);
    detent(1, 1'b0, 1'b1, 359);
    detent(1, 1'b0, 1'b1, 359);

    // Fast-spin instance: close detents use STEP*FAST_MULT
    detent(2, 1'b0, 1'b1, 18);
    repeat (10) @(negedge clk);
    detent(2, 1'b0, 1'b1, 108);
    repeat (200) @(negedge clk);
    detent(2, 1'b0, 1'b1, 126);

    repeat (30) @(negedge clk);
    chk("step_queue_drained", step_q.size(), 0);
    chk("commit_queue_drained", com_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
